// File: rtl/rom_loader.sv
// rom_loader: boot-time program loader for the single-cycle RISC-V core.
// Accepts a framed byte stream (LEN0, LEN1, 4*N data bytes, LSB first),
// writes the assembled 32-bit words into the instruction ROM write port,
// and holds the core in reset until the whole program is committed.
// Optional feature macro: ROM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte covering LEN0, LEN1 and all data bytes.
module rom_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the last data word (or an empty frame) is seen.
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        restart;
    logic [7:0]  len_lo;
    logic [15:0] len_word;
    logic        len_too_big;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic        last_word;
    logic [1:0]  byte_idx;
    logic [23:0] asm_reg;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept      = in_valid && in_ready;
    assign restart     = start && (state == S_DONE || state == S_ERR);
    assign len_word    = {in_data, len_lo};
    assign len_too_big = {1'b0, len_word} > DEPTH_W;
    assign last_word   = (word_cnt == n_words - 16'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LEN0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the state-derived handshake and status outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_LEN0: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = S_LEN1;
                end
            end
            S_LEN1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_too_big) begin
                        next_state = S_ERR;
                    end else if (len_word == 16'd0) begin
                        next_state = S_TAIL;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_idx == 2'd3 && last_word) begin
                    next_state = S_TAIL;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = (in_data == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = S_LEN0;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    next_state = S_LEN0;
                end
            end
            default: next_state = S_LEN0;
        endcase
    end

    // Byte capture, word assembly, ROM write strobe and address advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo    <= 8'd0;
            n_words   <= 16'd0;
            word_cnt  <= 16'd0;
            byte_idx  <= 2'd0;
            asm_reg   <= 24'd0;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= 32'd0;
        end else begin
            rom_we <= 1'b0;
            // The address moves one cycle after the strobe, but not past the
            // final word, so it cannot wrap even when N equals DEPTH.
            if (rom_we && state == S_DATA) begin
                rom_waddr <= rom_waddr + ADDR_W'(1);
            end
            if (accept) begin
                case (state)
                    S_LEN0: len_lo <= in_data;
                    S_LEN1: n_words <= len_word;
                    S_DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_reg[7:0]   <= in_data;
                            2'd1: asm_reg[15:8]  <= in_data;
                            2'd2: asm_reg[23:16] <= in_data;
                            default: begin
                                rom_we    <= 1'b1;
                                rom_wdata <= {in_data, asm_reg};
                                word_cnt  <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
            if (restart) begin
                word_cnt  <= 16'd0;
                byte_idx  <= 2'd0;
                rom_waddr <= '0;
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    // XOR accumulator over the length bytes and every data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= 8'd0;
        end else if (restart) begin
            csum <= 8'd0;
        end else if (accept && (state == S_LEN0 || state == S_LEN1 || state == S_DATA)) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    // Core reset release lags DONE by one cycle so the last ROM write lands first.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_n <= 1'b0;
        end else if (restart) begin
            cpu_rst_n <= 1'b0;
        end else begin
            cpu_rst_n <= (state == S_DONE);
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed self-checking bench for rom_loader.
// Honours ROM_LOADER_CHECKSUM_EN so the same bench fits both builds.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rom_we;
    logic [11:0] rom_waddr;
    logic [31:0] rom_wdata;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    logic        s_start;
    logic [7:0]  s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_rom_we;
    logic [3:0]  s_rom_waddr;
    logic [31:0] s_rom_wdata;
    logic        s_cpu_rst_n;
    logic        s_done;
    logic        s_err;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    int          wr_count = 0;
    int          s_wr_count = 0;
    logic [7:0]  frame_q [$];

    rom_loader #(.ADDR_W(12)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
    );

    rom_loader #(.ADDR_W(4)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .rom_we(s_rom_we), .rom_waddr(s_rom_waddr), .rom_wdata(s_rom_wdata),
        .cpu_rst_n(s_cpu_rst_n), .done(s_done), .err(s_err)
    );

    always #5 clk = ~clk;

    // Log every ROM write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            if (wr_count < 32) begin
                wr_addr[wr_count] = rom_waddr;
                wr_data[wr_count] = rom_wdata;
            end
            wr_count++;
        end
        if (s_rom_we === 1'b1) s_wr_count++;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        in_data = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic s_send_byte(input logic [7:0] b);
        s_in_data = b; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({in_ready, rom_we, cpu_rst_n, done, err} !== 5'b10000) begin errors++;
            $display("[TB] FAIL reset_flags: got %b expected 10000 (ready,we,rstn,done,err)", {in_ready, rom_we, cpu_rst_n, done, err}); end
        checks++; if (rom_waddr !== 12'h000) begin errors++;
            $display("[TB] FAIL reset_waddr: got %h expected 000", rom_waddr); end
        checks++; if (rom_wdata !== 32'h0) begin errors++;
            $display("[TB] FAIL reset_wdata: got %h expected 00000000", rom_wdata); end
    endtask

    task automatic test_basic_load();
        do_reset();
        wr_count = 0;
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef ROM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h92);
`endif
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], 0);
            if (i == 5) begin
                checks++; if ({rom_we, rom_waddr, rom_wdata} !== {1'b1, 12'h000, 32'h00000013}) begin errors++;
                    $display("[TB] FAIL write0_timing: got we=%b addr=%h data=%h expected we=1 addr=000 data=00000013", rom_we, rom_waddr, rom_wdata); end
            end
            if (i == 6) begin
                checks++; if ({rom_we, rom_waddr} !== {1'b0, 12'h001}) begin errors++;
                    $display("[TB] FAIL addr_advance: got we=%b addr=%h expected we=0 addr=001", rom_we, rom_waddr); end
            end
        end
        checks++; if ({done, err, cpu_rst_n, in_ready} !== 4'b1000) begin errors++;
            $display("[TB] FAIL basic_done_edge: got %b expected 1000 (done,err,rstn,ready)", {done, err, cpu_rst_n, in_ready}); end
        wait_cycles(1);
        checks++; if ({done, cpu_rst_n} !== 2'b11) begin errors++;
            $display("[TB] FAIL basic_rstn_rise: got %b expected 11 (done,rstn)", {done, cpu_rst_n}); end
        wait_cycles(2);
        checks++; if (wr_count !== 2) begin errors++;
            $display("[TB] FAIL basic_write_count: got %0d expected 2", wr_count); end
        checks++; if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {12'h000, 32'h00000013, 12'h001, 32'h00100093}) begin errors++;
            $display("[TB] FAIL basic_writes: got %h:%h %h:%h expected 000:00000013 001:00100093", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]); end
    endtask

    task automatic test_gaps();
        do_reset();
        wr_count = 0;
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef ROM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h92);
`endif
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], int'($urandom_range(5, 0)));
        end
        wait_cycles(3);
        checks++; if (wr_count !== 2) begin errors++;
            $display("[TB] FAIL gaps_write_count: got %0d expected 2", wr_count); end
        checks++; if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {12'h000, 32'h00000013, 12'h001, 32'h00100093}) begin errors++;
            $display("[TB] FAIL gaps_writes: got %h:%h %h:%h expected 000:00000013 001:00100093", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]); end
        checks++; if ({done, err, cpu_rst_n, in_ready} !== 4'b1010) begin errors++;
            $display("[TB] FAIL gaps_final: got %b expected 1010 (done,err,rstn,ready)", {done, err, cpu_rst_n, in_ready}); end
    endtask

    task automatic test_zero_len();
        do_reset();
        wr_count = 0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 1);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        checks++; if ({done, cpu_rst_n} !== 2'b10) begin errors++;
            $display("[TB] FAIL zero_done_edge: got %b expected 10 (done,rstn)", {done, cpu_rst_n}); end
        wait_cycles(2);
        checks++; if ({done, cpu_rst_n, err} !== 3'b110) begin errors++;
            $display("[TB] FAIL zero_final: got %b expected 110 (done,rstn,err)", {done, cpu_rst_n, err}); end
        checks++; if (wr_count !== 0) begin errors++;
            $display("[TB] FAIL zero_no_writes: got %0d expected 0", wr_count); end
    endtask

    task automatic test_too_long();
        do_reset();
        s_wr_count = 0;
        s_send_byte(8'h11);
        s_send_byte(8'h00);
        checks++; if ({s_err, s_done, s_in_ready, s_cpu_rst_n} !== 4'b1000) begin errors++;
            $display("[TB] FAIL toolong_err: got %b expected 1000 (err,done,ready,rstn)", {s_err, s_done, s_in_ready, s_cpu_rst_n}); end
        s_in_data = 8'h55; s_in_valid = 1'b1;
        wait_cycles(6);
        s_in_valid = 1'b0;
        checks++; if ({s_err, s_cpu_rst_n} !== 2'b10) begin errors++;
            $display("[TB] FAIL toolong_hold: got %b expected 10 (err,rstn)", {s_err, s_cpu_rst_n}); end
        checks++; if (s_wr_count !== 0) begin errors++;
            $display("[TB] FAIL toolong_no_writes: got %0d expected 0", s_wr_count); end
        s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0;
        checks++; if ({s_err, s_in_ready} !== 2'b01) begin errors++;
            $display("[TB] FAIL err_restart: got %b expected 01 (err,ready)", {s_err, s_in_ready}); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        checks++; if ({in_ready, rom_we, cpu_rst_n, done, err, rom_waddr} !== {5'b10000, 12'h000}) begin errors++;
            $display("[TB] FAIL midrst_state: got %b/%h expected 10000/000", {in_ready, rom_we, cpu_rst_n, done, err}, rom_waddr); end
        wr_count = 0;
        frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef ROM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h01);
`endif
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 0);
        wait_cycles(2);
        checks++; if ({wr_count, wr_addr[0], wr_data[0]} !== {32'd1, 12'h000, 32'hDDCCBBAA}) begin errors++;
            $display("[TB] FAIL midrst_writes: got n=%0d %h:%h expected n=1 000:ddccbbaa", wr_count, wr_addr[0], wr_data[0]); end
        checks++; if ({done, cpu_rst_n} !== 2'b11) begin errors++;
            $display("[TB] FAIL midrst_done: got %b expected 11 (done,rstn)", {done, cpu_rst_n}); end
    endtask

    task automatic test_restart();
        pulse_start();
        checks++; if ({cpu_rst_n, done, err, in_ready} !== 4'b0001) begin errors++;
            $display("[TB] FAIL restart_edge: got %b expected 0001 (rstn,done,err,ready)", {cpu_rst_n, done, err, in_ready}); end
        wr_count = 0;
        send_byte(8'h01, 0);
        pulse_start();
        frame_q = '{8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef ROM_LOADER_CHECKSUM_EN
        frame_q.push_back(8'h5A);
`endif
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], 0);
`ifdef ROM_LOADER_CHECKSUM_EN
        checks++; if ({err, done, cpu_rst_n} !== 3'b100) begin errors++;
            $display("[TB] FAIL badsum_err: got %b expected 100 (err,done,rstn)", {err, done, cpu_rst_n}); end
        wait_cycles(2);
        checks++; if ({err, cpu_rst_n} !== 2'b10) begin errors++;
            $display("[TB] FAIL badsum_hold: got %b expected 10 (err,rstn)", {err, cpu_rst_n}); end
`else
        wait_cycles(2);
        checks++; if ({done, err, cpu_rst_n} !== 3'b101) begin errors++;
            $display("[TB] FAIL reload_done: got %b expected 101 (done,err,rstn)", {done, err, cpu_rst_n}); end
`endif
        checks++; if ({wr_count, wr_addr[0], wr_data[0]} !== {32'd1, 12'h000, 32'h12345678}) begin errors++;
            $display("[TB] FAIL reload_writes: got n=%0d %h:%h expected n=1 000:12345678", wr_count, wr_addr[0], wr_data[0]); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        s_start = 1'b0; s_in_data = 8'h00; s_in_valid = 1'b0;
        test_reset();
        test_basic_load();
        test_gaps();
        test_zero_len();
        test_too_long();
        test_reset_mid_load();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
